// File: rtl/signal_frame_serializer.sv
// Frame snapshot buffer that streams WIDTH x HEIGHT pixel frames one pixel per beat on valid/ready.
// Optional boustrophedon scan order is enabled by defining SIGNAL_SERIALIZER_SERPENTINE_EN.
module signal_frame_serializer #(
  parameter int WIDTH_PIXELS      = 2,
  parameter int HEIGHT_PIXELS     = 2,
  parameter int PIXEL_SIZE_BITS   = 8,
  parameter int NUM_OF_SAMPLES    = 4,
  parameter int DEFAULT_INTENSITY = 0
) (
  input  logic                                                 clk,
  input  logic                                                 reset,
  input  logic [WIDTH_PIXELS*HEIGHT_PIXELS*PIXEL_SIZE_BITS-1:0] sig_flat,
  input  logic [WIDTH_PIXELS*HEIGHT_PIXELS-1:0]                 pixel_mask,
  input  logic                                                 sample_we,
  output logic [PIXEL_SIZE_BITS-1:0]                           m_tdata,
  output logic                                                 m_tvalid,
  input  logic                                                 m_tready,
  output logic                                                 m_tfirst,
  output logic                                                 m_tlast,
  output logic [$clog2(NUM_OF_SAMPLES+1)-1:0]                  level,
  output logic                                                 overflow,
  output logic [15:0]                                          drop_count
);

  localparam int NPIX  = WIDTH_PIXELS * HEIGHT_PIXELS;
  localparam int PB    = PIXEL_SIZE_BITS;
  localparam int IDX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int PTR_W = $clog2(NUM_OF_SAMPLES);
  localparam int LVL_W = $clog2(NUM_OF_SAMPLES + 1);

  localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(NUM_OF_SAMPLES);
  localparam logic [LVL_W-1:0] LEVEL_1  = LVL_W'(1);
  localparam logic [IDX_W-1:0] LAST_K   = IDX_W'(NPIX - 1);
  localparam logic [PB-1:0]    DEF_PIX  = PB'(DEFAULT_INTENSITY);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  logic [NPIX*PB-1:0] r_frameMem [NUM_OF_SAMPLES];
  logic [NPIX-1:0]    r_maskMem  [NUM_OF_SAMPLES];

  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [LVL_W-1:0] r_level;
  logic [0:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic [PB-1:0]    r_tdata;
  logic             r_tvalid;
  logic             r_tfirst;
  logic             r_tlast;
  logic             r_overflow;
  logic [15:0]      r_dropCount;

  logic             w_accept;
  logic             w_popLast;
  logic             w_full;
  logic             w_push;
  logic             w_drop;
  logic             w_load;
  logic [PTR_W-1:0] w_loadPtr;
  logic [IDX_W-1:0] w_loadK;
  logic [IDX_W-1:0] w_pixIdx;
  logic [PB-1:0]    w_loadData;

  // Maps beat index k to the stored pixel position p.
  function automatic logic [IDX_W-1:0] pixelOf(input logic [IDX_W-1:0] k);
`ifdef SIGNAL_SERIALIZER_SERPENTINE_EN
    int y;
    int x;
    y = int'(k) / WIDTH_PIXELS;
    x = int'(k) % WIDTH_PIXELS;
    if ((y % 2) == 1) x = WIDTH_PIXELS - 1 - x;
    return IDX_W'(y * WIDTH_PIXELS + x);
`else
    return k;
`endif
  endfunction

  assign w_accept  = r_tvalid & m_tready;
  assign w_popLast = w_accept & r_tlast;
  assign w_full    = (r_level == DEPTH_L);
  assign w_push    = sample_we & (~w_full | w_popLast);
  assign w_drop    = sample_we & w_full & ~w_popLast;

  // Choose which beat (frame, index) is loaded into the output registers at the next edge.
  always_comb begin
    w_load    = 1'b0;
    w_loadPtr = r_rdPtr;
    w_loadK   = '0;
    if (r_state == ST_IDLE) begin
      if (r_level != '0) w_load = 1'b1;
    end else if (w_accept) begin
      if (r_tlast) begin
        if (r_level > LEVEL_1) begin
          w_load    = 1'b1;
          w_loadPtr = r_rdPtr + PTR_W'(1);
        end
      end else begin
        w_load  = 1'b1;
        w_loadK = r_idx + IDX_W'(1);
      end
    end
  end

  assign w_pixIdx   = pixelOf(w_loadK);
  assign w_loadData = r_maskMem[w_loadPtr][w_pixIdx]
                    ? DEF_PIX
                    : r_frameMem[w_loadPtr][int'(w_pixIdx)*PB +: PB];

  always_ff @(posedge clk) begin
    if (!reset && w_push) begin
      r_frameMem[r_wrPtr] <= sig_flat;
      r_maskMem[r_wrPtr]  <= pixel_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_level     <= '0;
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_tdata     <= '0;
      r_tvalid    <= 1'b0;
      r_tfirst    <= 1'b0;
      r_tlast     <= 1'b0;
      r_overflow  <= 1'b0;
      r_dropCount <= '0;
    end else begin
      if (w_push)    r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_popLast) r_rdPtr <= r_rdPtr + PTR_W'(1);
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_popLast);

      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_dropCount != 16'hFFFF) r_dropCount <= r_dropCount + 16'd1;
      end

      // Output registers only change on a load or a final accept, so stalled beats hold.
      if (w_load) begin
        r_state  <= ST_STREAM;
        r_tvalid <= 1'b1;
        r_tdata  <= w_loadData;
        r_tfirst <= (w_loadK == '0);
        r_tlast  <= (w_loadK == LAST_K);
        r_idx    <= w_loadK;
      end else if (w_accept) begin
        r_state  <= ST_IDLE;
        r_tvalid <= 1'b0;
        r_tfirst <= 1'b0;
        r_tlast  <= 1'b0;
        r_idx    <= '0;
      end
    end
  end

  assign m_tdata    = r_tdata;
  assign m_tvalid   = r_tvalid;
  assign m_tfirst   = r_tfirst;
  assign m_tlast    = r_tlast;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_dropCount;

endmodule

// File: tb/tb_signal_frame_serializer.sv
// Directed testbench for signal_frame_serializer (2x2 frames, depth 4, masked value 0xAA).
// With SIGNAL_SERIALIZER_SERPENTINE_EN a second 3x2 instance checks the boustrophedon order.
module tb_signal_frame_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sig_flat;
  logic [3:0]  pixel_mask;
  logic        sample_we;
  logic [7:0]  m_tdata;
  logic        m_tvalid;
  logic        m_tready;
  logic        m_tfirst;
  logic        m_tlast;
  logic [2:0]  level;
  logic        overflow;
  logic [15:0] drop_count;

  int vectors     = 0;
  int miscompares = 0;
  int order [4];

  always #5 clk = ~clk;

  signal_frame_serializer #(
    .WIDTH_PIXELS(2), .HEIGHT_PIXELS(2), .PIXEL_SIZE_BITS(8),
    .NUM_OF_SAMPLES(4), .DEFAULT_INTENSITY('hAA)
  ) dut (
    .clk(clk), .reset(reset), .sig_flat(sig_flat), .pixel_mask(pixel_mask),
    .sample_we(sample_we), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tfirst(m_tfirst), .m_tlast(m_tlast), .level(level), .overflow(overflow),
    .drop_count(drop_count)
  );

`ifdef SIGNAL_SERIALIZER_SERPENTINE_EN
  logic [47:0] s_sig;
  logic [5:0]  s_mask;
  logic        s_we;
  logic [7:0]  s_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic        s_tfirst;
  logic        s_tlast;
  logic [2:0]  s_level;
  logic        s_overflow;
  logic [15:0] s_drop;

  signal_frame_serializer #(
    .WIDTH_PIXELS(3), .HEIGHT_PIXELS(2), .PIXEL_SIZE_BITS(8),
    .NUM_OF_SAMPLES(4), .DEFAULT_INTENSITY(0)
  ) u_serp (
    .clk(clk), .reset(reset), .sig_flat(s_sig), .pixel_mask(s_mask),
    .sample_we(s_we), .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tready(s_tready),
    .m_tfirst(s_tfirst), .m_tlast(s_tlast), .level(s_level), .overflow(s_overflow),
    .drop_count(s_drop)
  );
`endif

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setFrame(input int base, input logic [3:0] mask);
    for (int p = 0; p < 4; p++) sig_flat[p*8 +: 8] = 8'(base + p);
    pixel_mask = mask;
  endtask

  task automatic doReset;
    reset      = 1'b1;
    sample_we  = 1'b0;
    m_tready   = 1'b0;
    sig_flat   = '0;
    pixel_mask = '0;
`ifdef SIGNAL_SERIALIZER_SERPENTINE_EN
    s_we = 1'b0; s_tready = 1'b0; s_sig = '0; s_mask = '0;
`endif
    tick;
    tick;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    doReset;
    vectors++;
    if (m_tvalid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", m_tvalid); end
    vectors++;
    if (level !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    vectors++;
    if (overflow !== 1'b0 || drop_count !== 16'd0) begin
      miscompares++; $display("[TB] FAIL reset_overflow: got %b/%0d expected 0/0", overflow, drop_count);
    end
    vectors++;
    if (m_tdata !== 8'd0 || m_tfirst !== 1'b0 || m_tlast !== 1'b0) begin
      miscompares++; $display("[TB] FAIL reset_data: got %0d/%b/%b expected 0/0/0", m_tdata, m_tfirst, m_tlast);
    end
  endtask

  task automatic test_single;
    doReset;
    m_tready = 1'b1;
    setFrame(10, 4'b0000);
    sample_we = 1'b1;
    tick;
    sample_we = 1'b0;
    vectors++;
    if (m_tvalid !== 1'b0 || level !== 3'd1) begin
      miscompares++; $display("[TB] FAIL single_t1: got valid %b level %0d expected 0/1", m_tvalid, level);
    end
    tick;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'(10 + order[k])) begin
        miscompares++; $display("[TB] FAIL single_beat%0d: got %b/%0d expected 1/%0d", k, m_tvalid, m_tdata, 10 + order[k]);
      end
      vectors++;
      if (m_tfirst !== (k == 0) || m_tlast !== (k == 3) || level !== 3'd1) begin
        miscompares++; $display("[TB] FAIL single_flags%0d: got first %b last %b level %0d", k, m_tfirst, m_tlast, level);
      end
      tick;
    end
    vectors++;
    if (m_tvalid !== 1'b0 || level !== 3'd0) begin
      miscompares++; $display("[TB] FAIL single_end: got valid %b level %0d expected 0/0", m_tvalid, level);
    end
  endtask

  task automatic test_overflow;
    doReset;
    for (int f = 0; f < 5; f++) begin
      setFrame(4 * f, 4'b0000);
      sample_we = 1'b1;
      tick;
    end
    sample_we = 1'b0;
    vectors++;
    if (level !== 3'd4 || overflow !== 1'b1 || drop_count !== 16'd1) begin
      miscompares++; $display("[TB] FAIL ovf_state: got level %0d ovf %b drops %0d expected 4/1/1", level, overflow, drop_count);
    end
    m_tready = 1'b1;
    for (int j = 0; j < 16; j++) begin
      vectors++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'(4 * (j / 4) + order[j % 4])) begin
        miscompares++; $display("[TB] FAIL ovf_beat%0d: got %b/%0d expected 1/%0d", j, m_tvalid, m_tdata, 4 * (j / 4) + order[j % 4]);
      end
      vectors++;
      if (m_tfirst !== ((j % 4) == 0) || m_tlast !== ((j % 4) == 3)) begin
        miscompares++; $display("[TB] FAIL ovf_flags%0d: got first %b last %b", j, m_tfirst, m_tlast);
      end
      tick;
    end
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (m_tvalid !== 1'b0 || level !== 3'd0) begin
        miscompares++; $display("[TB] FAIL ovf_extra%0d: got valid %b level %0d expected 0/0", c, m_tvalid, level);
      end
      tick;
    end
  endtask

  task automatic test_mask;
    logic [7:0] expPix [4];
    expPix = '{8'hAA, 8'd21, 8'hAA, 8'd23};
    doReset;
    m_tready = 1'b1;
    setFrame(20, 4'b0101);
    sample_we = 1'b1;
    tick;
    sample_we = 1'b0;
    tick;
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (m_tvalid !== 1'b1 || m_tdata !== expPix[order[k]]) begin
        miscompares++; $display("[TB] FAIL mask_beat%0d: got %b/%0h expected 1/%0h", k, m_tvalid, m_tdata, expPix[order[k]]);
      end
      tick;
    end
  endtask

  task automatic test_stall;
    int got;
    int cyc;
    logic       prevV;
    logic [7:0] prevD;
    logic       prevF;
    logic       prevL;
    doReset;
    setFrame(30, 4'b0000);
    sample_we = 1'b1;
    tick;
    sample_we = 1'b0;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 60) begin
      m_tready = (cyc >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
      prevV = m_tvalid; prevD = m_tdata; prevF = m_tfirst; prevL = m_tlast;
      if (m_tvalid && m_tready) begin
        vectors++;
        if (m_tdata !== 8'(30 + order[got]) || m_tfirst !== (got == 0) || m_tlast !== (got == 3)) begin
          miscompares++; $display("[TB] FAIL stall_beat%0d: got %0d f%b l%b expected %0d", got, m_tdata, m_tfirst, m_tlast, 30 + order[got]);
        end
        got++;
      end
      tick;
      cyc++;
      if (prevV && !m_tready) begin
        vectors++;
        if (m_tvalid !== 1'b1 || m_tdata !== prevD || m_tfirst !== prevF || m_tlast !== prevL) begin
          miscompares++; $display("[TB] FAIL stall_hold: got %b/%0d expected 1/%0d", m_tvalid, m_tdata, prevD);
        end
      end
    end
    vectors++;
    if (got !== 4) begin miscompares++; $display("[TB] FAIL stall_count: got %0d beats expected 4", got); end
    m_tready = 1'b1;
    tick;
    vectors++;
    if (m_tvalid !== 1'b0 || level !== 3'd0) begin
      miscompares++; $display("[TB] FAIL stall_dup: got valid %b level %0d expected 0/0", m_tvalid, level);
    end
  endtask

  task automatic test_full_pop;
    doReset;
    for (int f = 0; f < 4; f++) begin
      setFrame(40 + 4 * f, 4'b0000);
      sample_we = 1'b1;
      tick;
    end
    sample_we = 1'b0;
    vectors++;
    if (level !== 3'd4) begin miscompares++; $display("[TB] FAIL fullpop_fill: got level %0d expected 4", level); end
    m_tready = 1'b1;
    for (int j = 0; j < 20; j++) begin
      vectors++;
      if (m_tvalid !== 1'b1 || m_tdata !== 8'(40 + 4 * (j / 4) + order[j % 4])) begin
        miscompares++; $display("[TB] FAIL fullpop_beat%0d: got %b/%0d expected 1/%0d", j, m_tvalid, m_tdata, 40 + 4 * (j / 4) + order[j % 4]);
      end
      if (j == 3) begin
        setFrame(56, 4'b0000);
        sample_we = 1'b1;
      end
      tick;
      sample_we = 1'b0;
      if (j == 3) begin
        vectors++;
        if (level !== 3'd4 || overflow !== 1'b0 || drop_count !== 16'd0) begin
          miscompares++; $display("[TB] FAIL fullpop_nodrop: got level %0d ovf %b drops %0d expected 4/0/0", level, overflow, drop_count);
        end
      end
    end
    vectors++;
    if (m_tvalid !== 1'b0 || level !== 3'd0) begin
      miscompares++; $display("[TB] FAIL fullpop_end: got valid %b level %0d expected 0/0", m_tvalid, level);
    end
  endtask

  task automatic test_reset_mid;
    doReset;
    for (int f = 0; f < 5; f++) begin
      setFrame(60 + 4 * f, 4'b0000);
      sample_we = 1'b1;
      tick;
    end
    sample_we = 1'b0;
    m_tready = 1'b1;
    tick;
    tick;
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'(60 + order[2]) || overflow !== 1'b1) begin
      miscompares++; $display("[TB] FAIL midrst_pre: got %b/%0d ovf %b expected 1/%0d/1", m_tvalid, m_tdata, overflow, 60 + order[2]);
    end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    vectors++;
    if (m_tvalid !== 1'b0 || level !== 3'd0 || overflow !== 1'b0 || drop_count !== 16'd0) begin
      miscompares++; $display("[TB] FAIL midrst_post: got valid %b level %0d ovf %b drops %0d expected 0/0/0/0", m_tvalid, level, overflow, drop_count);
    end
    setFrame(100, 4'b0000);
    sample_we = 1'b1;
    tick;
    sample_we = 1'b0;
    tick;
    vectors++;
    if (m_tvalid !== 1'b1 || m_tdata !== 8'd100 || m_tfirst !== 1'b1) begin
      miscompares++; $display("[TB] FAIL midrst_fresh: got %b/%0d f%b expected 1/100/1", m_tvalid, m_tdata, m_tfirst);
    end
  endtask

`ifdef SIGNAL_SERIALIZER_SERPENTINE_EN
  task automatic test_serpentine;
    logic [7:0] expSerp [6];
    expSerp = '{8'd0, 8'd1, 8'd2, 8'd5, 8'd4, 8'd3};
    doReset;
    s_tready = 1'b1;
    for (int p = 0; p < 6; p++) s_sig[p*8 +: 8] = 8'(p);
    s_we = 1'b1;
    tick;
    s_we = 1'b0;
    tick;
    for (int k = 0; k < 6; k++) begin
      vectors++;
      if (s_tvalid !== 1'b1 || s_tdata !== expSerp[k] || s_tfirst !== (k == 0) || s_tlast !== (k == 5)) begin
        miscompares++; $display("[TB] FAIL serp_beat%0d: got %b/%0d f%b l%b expected 1/%0d", k, s_tvalid, s_tdata, s_tfirst, s_tlast, expSerp[k]);
      end
      tick;
    end
  endtask
`endif

  initial begin
`ifdef SIGNAL_SERIALIZER_SERPENTINE_EN
    order = '{0, 1, 3, 2};
`else
    order = '{0, 1, 2, 3};
`endif
    test_reset;
    test_single;
    test_overflow;
    test_mask;
    test_stall;
    test_full_pop;
    test_reset_mid;
`ifdef SIGNAL_SERIALIZER_SERPENTINE_EN
    test_serpentine;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
